// File: rtl/pktfifo.sv
// rtl/pktfifo.sv - synchronous packet FIFO with commit, abort and overflow drop
module pktfifo #(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter bit OPT_PACKET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_last,
    input  logic              i_abort,
    input  logic [LGFLEN:0]   i_afull_thresh,
    input  logic [LGFLEN:0]   i_aempty_thresh,
    output logic              o_full,
    output logic [LGFLEN:0]   o_wfill,
    output logic              o_afull,
    output logic              o_drop,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_rfill,
    output logic              o_aempty
);
    localparam int FLEN = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT = {1'b1, {LGFLEN{1'b0}}};

    // Each entry carries the data beat plus its last tag in the MSB.
    logic [BW:0]     r_mem [FLEN];
    logic [LGFLEN:0] r_wr_addr;
    logic [LGFLEN:0] r_commit_addr;
    logic [LGFLEN:0] r_rd_addr;
    logic            r_poison;
    logic            r_drop;

    logic [LGFLEN:0] w_wfill;
    logic [LGFLEN:0] w_rfill;
    logic            w_full;
    logic            w_empty;
    logic            w_abort;
    logic            w_wr;
    logic            w_rd;
    logic            w_commit;
    logic            w_overflow;
    logic            w_drop;

    // Fill levels come from registered pointers only; the extra MSB separates full from empty.
    assign w_wfill = r_wr_addr - r_rd_addr;
    assign w_rfill = r_commit_addr - r_rd_addr;
    assign w_full  = (w_wfill == FULL_CNT);
    assign w_empty = (w_rfill == '0);

    // Abort only exists in packet mode; it beats any write in the same cycle.
    assign w_abort    = OPT_PACKET && i_abort;
    assign w_wr       = i_wr && !w_full && !r_poison && !w_abort;
    assign w_rd       = i_rd && !w_empty;
    assign w_commit   = w_wr && (i_last || !OPT_PACKET);
    // A write hitting a full FIFO, or any write while poisoned, belongs to a packet that cannot complete.
    assign w_overflow = OPT_PACKET && !w_abort && i_wr && (w_full || r_poison);
    // The doomed packet is thrown away once its last beat shows up.
    assign w_drop     = w_overflow && i_last;

    // Store accepted beats; storage needs no reset since pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_addr[LGFLEN-1:0]] <= {i_last, i_data};
        end
    end

    // Advance write, commit and read pointers; abort or drop rewinds staging to the commit point.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_addr     <= '0;
            r_commit_addr <= '0;
            r_rd_addr     <= '0;
        end else begin
            if (w_abort || w_drop) begin
                r_wr_addr <= r_commit_addr;
            end else if (w_wr) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (w_commit) begin
                r_commit_addr <= r_wr_addr + 1'b1;
            end
            if (w_rd) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Track the poisoned-packet state and emit a one-cycle drop pulse after the discard.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_poison <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_abort || w_drop) begin
                r_poison <= 1'b0;
            end else if (w_overflow) begin
                r_poison <= 1'b1;
            end
        end
    end

    assign o_full   = w_full;
    assign o_wfill  = w_wfill;
    assign o_afull  = (w_wfill >= i_afull_thresh);
    assign o_drop   = r_drop;
    assign o_empty  = w_empty;
    assign o_rfill  = w_rfill;
    assign o_aempty = (w_rfill <= i_aempty_thresh);
    assign o_data   = r_mem[r_rd_addr[LGFLEN-1:0]][BW-1:0];
    assign o_last   = r_mem[r_rd_addr[LGFLEN-1:0]][BW];

endmodule

// File: tb/tb_pktfifo.sv
// tb/tb_pktfifo.sv - directed self-checking bench for pktfifo
module tb_pktfifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_wr = 0, a_last = 0, a_abort = 0, a_rd = 0;
    logic [7:0] a_din = 0;
    logic [4:0] a_afull_t = 5'd16, a_aempty_t = 5'd0;
    logic       a_full, a_afull, a_drop, a_last_o, a_empty, a_aempty;
    logic [4:0] a_wfill, a_rfill;
    logic [7:0] a_dout;

    logic       b_wr = 0, b_last = 0, b_abort = 0, b_rd = 0;
    logic [7:0] b_din = 0;
    logic [4:0] b_afull_t = 5'd12, b_aempty_t = 5'd2;
    logic       b_full, b_afull, b_drop, b_last_o, b_empty, b_aempty;
    logic [4:0] b_wfill, b_rfill;
    logic [7:0] b_dout;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pktfifo #(.BW(8), .LGFLEN(4), .OPT_PACKET(1'b1)) u_pkt (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr(a_wr), .i_data(a_din), .i_last(a_last),
        .i_abort(a_abort), .i_afull_thresh(a_afull_t), .i_aempty_thresh(a_aempty_t),
        .o_full(a_full), .o_wfill(a_wfill), .o_afull(a_afull), .o_drop(a_drop),
        .i_rd(a_rd), .o_data(a_dout), .o_last(a_last_o), .o_empty(a_empty),
        .o_rfill(a_rfill), .o_aempty(a_aempty)
    );

    pktfifo #(.BW(8), .LGFLEN(4), .OPT_PACKET(1'b0)) u_plain (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr(b_wr), .i_data(b_din), .i_last(b_last),
        .i_abort(b_abort), .i_afull_thresh(b_afull_t), .i_aempty_thresh(b_aempty_t),
        .o_full(b_full), .o_wfill(b_wfill), .o_afull(b_afull), .o_drop(b_drop),
        .i_rd(b_rd), .o_data(b_dout), .o_last(b_last_o), .o_empty(b_empty),
        .o_rfill(b_rfill), .o_aempty(b_aempty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_afull_t = 5'd12;
        a_aempty_t = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (a_empty !== 1'b1) $display("FAIL rst_empty: got %0d want 1", a_empty); else n_pass++;
        n_total++; if (a_full !== 1'b0) $display("FAIL rst_full: got %0d want 0", a_full); else n_pass++;
        n_total++; if (a_wfill !== 5'd0) $display("FAIL rst_wfill: got %0d want 0", a_wfill); else n_pass++;
        n_total++; if (a_rfill !== 5'd0) $display("FAIL rst_rfill: got %0d want 0", a_rfill); else n_pass++;
        n_total++; if (a_drop !== 1'b0) $display("FAIL rst_drop: got %0d want 0", a_drop); else n_pass++;
        n_total++; if (a_aempty !== 1'b1) $display("FAIL rst_aempty: got %0d want 1", a_aempty); else n_pass++;
        n_total++; if (a_afull !== 1'b0) $display("FAIL rst_afull12: got %0d want 0", a_afull); else n_pass++;
        a_afull_t = 5'd0;
        #1;
        n_total++; if (a_afull !== 1'b1) $display("FAIL rst_afull0: got %0d want 1", a_afull); else n_pass++;
        a_afull_t = 5'd16;
        a_aempty_t = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_commit_gating();
        logic [7:0] vals [3];
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            a_wr = 1'b1; a_din = vals[i]; a_last = (i == 2);
            tick();
            if (i < 2) begin
                n_total++; if (a_empty !== 1'b1) $display("FAIL cg_empty_beat%0d: got %0d want 1", i, a_empty); else n_pass++;
                n_total++; if (a_wfill !== 5'(i + 1)) $display("FAIL cg_wfill_beat%0d: got %0d want %0d", i, a_wfill, i + 1); else n_pass++;
            end
        end
        a_wr = 1'b0; a_last = 1'b0;
        n_total++; if (a_empty !== 1'b0) $display("FAIL cg_empty_commit: got %0d want 0", a_empty); else n_pass++;
        n_total++; if (a_rfill !== 5'd3) $display("FAIL cg_rfill: got %0d want 3", a_rfill); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (a_dout !== vals[i]) $display("FAIL cg_data%0d: got %0h want %0h", i, a_dout, vals[i]); else n_pass++;
            n_total++; if (a_last_o !== (i == 2)) $display("FAIL cg_last%0d: got %0d want %0d", i, a_last_o, (i == 2)); else n_pass++;
            a_rd = 1'b1;
            tick();
        end
        a_rd = 1'b0;
        n_total++; if (a_empty !== 1'b1) $display("FAIL cg_empty_end: got %0d want 1", a_empty); else n_pass++;
    endtask

    task automatic test_abort();
        a_wr = 1'b1; a_last = 1'b0; a_din = 8'h10; tick();
        a_din = 8'h11; tick();
        n_total++; if (a_wfill !== 5'd2) $display("FAIL ab_staged: got %0d want 2", a_wfill); else n_pass++;
        a_din = 8'h12; a_abort = 1'b1; tick();
        a_abort = 1'b0; a_wr = 1'b0;
        n_total++; if (a_wfill !== 5'd0) $display("FAIL ab_wfill: got %0d want 0", a_wfill); else n_pass++;
        n_total++; if (a_empty !== 1'b1) $display("FAIL ab_empty: got %0d want 1", a_empty); else n_pass++;
        a_wr = 1'b1; a_din = 8'h20; a_last = 1'b1; tick();
        a_wr = 1'b0; a_last = 1'b0;
        n_total++; if (a_rfill !== 5'd1) $display("FAIL ab_rfill: got %0d want 1", a_rfill); else n_pass++;
        n_total++; if (a_dout !== 8'h20) $display("FAIL ab_data: got %0h want 20", a_dout); else n_pass++;
        n_total++; if (a_last_o !== 1'b1) $display("FAIL ab_last: got %0d want 1", a_last_o); else n_pass++;
        a_rd = 1'b1; tick(); a_rd = 1'b0;
        n_total++; if (a_empty !== 1'b1) $display("FAIL ab_drain: got %0d want 1", a_empty); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 14; i++) begin
            a_wr = 1'b1; a_din = 8'(8'h30 + i); a_last = 1'b1; tick();
        end
        n_total++; if (a_rfill !== 5'd14) $display("FAIL ov_rfill14: got %0d want 14", a_rfill); else n_pass++;
        a_din = 8'h50; a_last = 1'b0; tick();
        n_total++; if (a_wfill !== 5'd15) $display("FAIL ov_wfill15: got %0d want 15", a_wfill); else n_pass++;
        a_din = 8'h51; tick();
        n_total++; if (a_wfill !== 5'd16) $display("FAIL ov_wfill16: got %0d want 16", a_wfill); else n_pass++;
        n_total++; if (a_full !== 1'b1) $display("FAIL ov_full: got %0d want 1", a_full); else n_pass++;
        a_din = 8'h52; tick();
        n_total++; if (a_wfill !== 5'd16) $display("FAIL ov_beat3_wfill: got %0d want 16", a_wfill); else n_pass++;
        n_total++; if (a_drop !== 1'b0) $display("FAIL ov_beat3_drop: got %0d want 0", a_drop); else n_pass++;
        a_din = 8'h53; a_last = 1'b1; tick();
        a_wr = 1'b0; a_last = 1'b0;
        n_total++; if (a_drop !== 1'b1) $display("FAIL ov_drop: got %0d want 1", a_drop); else n_pass++;
        n_total++; if (a_wfill !== 5'd14) $display("FAIL ov_wfill_after: got %0d want 14", a_wfill); else n_pass++;
        n_total++; if (a_rfill !== 5'd14) $display("FAIL ov_rfill_after: got %0d want 14", a_rfill); else n_pass++;
        n_total++; if (a_full !== 1'b0) $display("FAIL ov_full_after: got %0d want 0", a_full); else n_pass++;
        tick();
        n_total++; if (a_drop !== 1'b0) $display("FAIL ov_drop_pulse: got %0d want 0", a_drop); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            n_total++; if (a_dout !== 8'(8'h30 + i)) $display("FAIL ov_read%0d: got %0h want %0h", i, a_dout, 8'(8'h30 + i)); else n_pass++;
            a_rd = 1'b1; tick();
        end
        a_rd = 1'b0;
        n_total++; if (a_empty !== 1'b1 || a_wfill !== 5'd0) $display("FAIL ov_drained: got empty=%0d wfill=%0d want 1/0", a_empty, a_wfill); else n_pass++;
    endtask

    task automatic test_full_edge();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1'b1; a_din = 8'(8'h60 + i); a_last = 1'b1; tick();
        end
        n_total++; if (a_full !== 1'b1) $display("FAIL fe_full: got %0d want 1", a_full); else n_pass++;
        a_din = 8'h99; a_rd = 1'b1; tick();
        a_wr = 1'b0; a_rd = 1'b0; a_last = 1'b0;
        n_total++; if (a_wfill !== 5'd15) $display("FAIL fe_wfill: got %0d want 15", a_wfill); else n_pass++;
        n_total++; if (a_full !== 1'b0) $display("FAIL fe_notfull: got %0d want 0", a_full); else n_pass++;
        for (int i = 1; i < 16; i++) begin
            n_total++; if (a_dout !== 8'(8'h60 + i)) $display("FAIL fe_read%0d: got %0h want %0h", i, a_dout, 8'(8'h60 + i)); else n_pass++;
            a_rd = 1'b1; tick();
        end
        a_rd = 1'b0;
        n_total++; if (a_empty !== 1'b1) $display("FAIL fe_drained: got %0d want 1", a_empty); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 5 + 3);
            a_wr = 1'b1; a_din = v; a_last = 1'b1;
            a_rd = (i % 3 != 0) && (q.size() != 0);
            if (a_rd) begin
                n_total++; if (a_dout !== q[0]) $display("FAIL wr_data%0d: got %0h want %0h", i, a_dout, q[0]); else n_pass++;
                void'(q.pop_front());
            end
            tick();
            q.push_back(v);
            n_total++; if (a_wfill !== 5'(q.size())) $display("FAIL wr_fill%0d: got %0d want %0d", i, a_wfill, q.size()); else n_pass++;
        end
        a_wr = 1'b0; a_last = 1'b0;
        while (q.size() != 0) begin
            n_total++; if (a_dout !== q[0]) $display("FAIL wr_drain: got %0h want %0h", a_dout, q[0]); else n_pass++;
            void'(q.pop_front());
            a_rd = 1'b1; tick();
        end
        a_rd = 1'b0;
        n_total++; if (a_empty !== 1'b1) $display("FAIL wr_empty: got %0d want 1", a_empty); else n_pass++;
    endtask

    task automatic test_thresholds_reset();
        for (int i = 0; i < 12; i++) begin
            b_wr = 1'b1; b_din = 8'(8'h70 + i); b_last = 1'b0; tick();
            if (i == 1) begin
                n_total++; if (b_aempty !== 1'b1) $display("FAIL th_aempty_fill2: got %0d want 1", b_aempty); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if (b_aempty !== 1'b0) $display("FAIL th_aempty_fill3: got %0d want 0", b_aempty); else n_pass++;
            end
            if (i == 10) begin
                n_total++; if (b_afull !== 1'b0) $display("FAIL th_afull_11: got %0d want 0", b_afull); else n_pass++;
            end
        end
        b_wr = 1'b0;
        n_total++; if (b_afull !== 1'b1) $display("FAIL th_afull_12: got %0d want 1", b_afull); else n_pass++;
        n_total++; if (b_rfill !== 5'd12) $display("FAIL th_rfill12: got %0d want 12", b_rfill); else n_pass++;
        for (int j = 0; j < 10; j++) begin
            n_total++; if (b_dout !== 8'(8'h70 + j)) $display("FAIL th_read%0d: got %0h want %0h", j, b_dout, 8'(8'h70 + j)); else n_pass++;
            b_rd = 1'b1; tick();
            if (j == 8) begin
                n_total++; if (b_aempty !== 1'b0) $display("FAIL th_aempty_r3: got %0d want 0", b_aempty); else n_pass++;
            end
        end
        b_rd = 1'b0;
        n_total++; if (b_aempty !== 1'b1 || b_rfill !== 5'd2) $display("FAIL th_aempty_r2: got aempty=%0d rfill=%0d want 1/2", b_aempty, b_rfill); else n_pass++;
        b_wr = 1'b1; b_abort = 1'b1; b_din = 8'h7C; tick();
        b_abort = 1'b0;
        n_total++; if (b_wfill !== 5'd3) $display("FAIL th_abort_ignored: got %0d want 3", b_wfill); else n_pass++;
        for (int i = 0; i < 13; i++) begin
            b_din = 8'(8'h80 + i); tick();
        end
        n_total++; if (b_full !== 1'b1 || b_wfill !== 5'd16) $display("FAIL th_full: got full=%0d wfill=%0d want 1/16", b_full, b_wfill); else n_pass++;
        b_din = 8'hEE; b_last = 1'b1; tick();
        b_last = 1'b0;
        n_total++; if (b_wfill !== 5'd16 || b_drop !== 1'b0) $display("FAIL th_overflow: got wfill=%0d drop=%0d want 16/0", b_wfill, b_drop); else n_pass++;
        n_total++; if (b_dout !== 8'h7A) $display("FAIL th_head: got %0h want 7a", b_dout); else n_pass++;
        b_wr = 1'b1; b_din = 8'h55;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (b_wfill !== 5'd0 || b_rfill !== 5'd0) $display("FAIL th_rst_fill: got wfill=%0d rfill=%0d want 0/0", b_wfill, b_rfill); else n_pass++;
        n_total++; if (b_empty !== 1'b1 || b_full !== 1'b0) $display("FAIL th_rst_flags: got empty=%0d full=%0d want 1/0", b_empty, b_full); else n_pass++;
        n_total++; if (b_afull !== 1'b0 || b_aempty !== 1'b1) $display("FAIL th_rst_thresh: got afull=%0d aempty=%0d want 0/1", b_afull, b_aempty); else n_pass++;
        b_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_commit_gating();
        test_abort();
        test_overflow();
        test_full_edge();
        test_wrap();
        test_thresholds_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
